ncl_addn_clocked: RTL

Parametrised dual-rail adder: WIDTH-bit A plus B plus carry-in, NCL DATA/NULL encoding with completion handshakes on both sides, evaluated inside a single clock domain. It generalises the two-half-adder full adder to an N-bit word by resolving one bit per clock, carry rippling through a counter-driven datapath. It sits between dual-rail producers and consumers that follow the codebase's COMP handshake polarity: 1 requests DATA, 0 requests NULL.

---
 rtl/ncl_addn_clocked_if.sv | 27 ++
 rtl/ncl_addn_clocked.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ncl_addn_clocked_if.sv
// Dual-rail operand/result bundle for ncl_addn_clocked.
// Pair i of a bus sits at [2i+1:2i]: [2i] is rail "0" and [2i+1] is rail "1".
// COMP polarity: 1 requests DATA, 0 requests NULL.
interface ncl_addn_clocked_if #(
  parameter int WIDTH = 8
);
  logic [2*WIDTH-1:0] A;
  logic [2*WIDTH-1:0] B;
  logic [1:0]         carryin;
  logic               ABCOMP;
  logic [2*WIDTH-1:0] sum;
  logic [1:0]         carryout;
  logic               sumCOMP;
  logic               err;

  // Producer/consumer side
  modport master (
    output A, B, carryin, sumCOMP,
    input  ABCOMP, sum, carryout, err
  );

  // Adder side
  modport slave (
    input  A, B, carryin, sumCOMP,
    output ABCOMP, sum, carryout, err
  );
endinterface

// File: rtl/ncl_addn_clocked.sv
// Clocked dual-rail (NCL) WIDTH-bit adder: latches a complete DATA wavefront,
// ripples one bit per clock, then presents pure DATA / pure NULL results under
// the ABCOMP / sumCOMP completion handshakes.
// Optional feature macro: NCL_ADDN_ERRCHK_EN (sticky illegal-code flag on err;
// 11 pairs then block detection). Without it, err is 0 and rail 1 dominates.
module ncl_addn_clocked #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                initN,
  ncl_addn_clocked_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    READY,
    OUT
  } state_t;

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t              r_state;
  logic                r_abcomp;
  logic                r_null_seen;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_s;
  logic                r_c;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_sum;
  logic [1:0]          r_cout;

  logic [WIDTH-1:0]    w_a_bit;
  logic [WIDTH-1:0]    w_b_bit;
  logic [WIDTH-1:0]    w_a_any;
  logic [WIDTH-1:0]    w_b_any;
  logic                w_c_bit;
  logic                w_c_any;
  logic                w_illegal;
  logic                w_all_data;
  logic                w_all_null;
  logic                w_bit_a;
  logic                w_bit_b;

  // Single-rail encoding of a resolved word onto dual-rail pairs
  function automatic logic [2*WIDTH-1:0] f_enc(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      e[2*i +: 2] = {v[i], ~v[i]};
    end
    return e;
  endfunction

  // Per-pair decode of the input wavefront (rail 1 carries the bit value)
  always_comb begin
    w_a_bit = '0;
    w_b_bit = '0;
    w_a_any = '0;
    w_b_any = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_a_bit[i] = bus.A[2*i+1];
      w_b_bit[i] = bus.B[2*i+1];
      w_a_any[i] = |bus.A[2*i +: 2];
      w_b_any[i] = |bus.B[2*i +: 2];
    end
    w_c_bit = bus.carryin[1];
    w_c_any = |bus.carryin;
  end

`ifdef NCL_ADDN_ERRCHK_EN
  logic r_err;

  // Any 11 pair on the inputs is an illegal code
  always_comb begin
    w_illegal = &bus.carryin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_illegal = w_illegal | (&bus.A[2*i +: 2]) | (&bus.B[2*i +: 2]);
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge initN) begin
    if (!initN) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_illegal = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // An illegal pair is non-zero, so it already blocks complete-NULL
  assign w_all_data = (&w_a_any) & (&w_b_any) & w_c_any & ~w_illegal;
  assign w_all_null = ~(|bus.A) & ~(|bus.B) & ~(|bus.carryin);

  assign w_bit_a = r_a[r_cnt];
  assign w_bit_b = r_b[r_cnt];

  // Handshake FSM and bit-serial ripple datapath
  always_ff @(posedge clk or negedge initN) begin
    if (!initN) begin
      r_state     <= IDLE;
      r_abcomp    <= 1'b1;
      r_null_seen <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= '0;
    end else begin
      // NULL wavefront may arrive in any state; remember it for IDLE
      if (w_all_null) begin
        r_null_seen <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_abcomp) begin
            if (w_all_data) begin
              r_a         <= w_a_bit;
              r_b         <= w_b_bit;
              r_c         <= w_c_bit;
              r_cnt       <= '0;
              r_abcomp    <= 1'b0;
              r_null_seen <= 1'b0;
              r_state     <= CALC;
            end
          end else if (r_null_seen || w_all_null) begin
            r_abcomp <= 1'b1;
          end
        end
        CALC: begin
          r_s[r_cnt] <= w_bit_a ^ w_bit_b ^ r_c;
          r_c        <= (w_bit_a & w_bit_b) | (w_bit_a & r_c) | (w_bit_b & r_c);
          r_cnt      <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= READY;
          end
        end
        READY: begin
          if (bus.sumCOMP) begin
            r_sum   <= f_enc(r_s);
            r_cout  <= {r_c, ~r_c};
            r_state <= OUT;
          end
        end
        OUT: begin
          if (!bus.sumCOMP) begin
            r_sum   <= '0;
            r_cout  <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ABCOMP   = r_abcomp;
  assign bus.sum      = r_sum;
  assign bus.carryout = r_cout;

endmodule
